// File: rtl/sseg_pkg.sv
// ----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the seven-segment capture decoder:
//   - digit / segment / word width constants
//   - the sixteen active-low segment patterns (bit0 = a .. bit6 = g, 0 = lit)
//   - SEG_BLANK, the all-segments-off pattern
//   - FSM state encoding (ST_SETTLE, ST_LOCKED)
// ----------------------------------------------------------------------------
package sseg_pkg;

    localparam int DIGITS  = 4;
    localparam int SEG_W   = 7;
    localparam int NIB_W   = 4;
    localparam int WORD_W  = DIGITS * SEG_W;
    localparam int VALUE_W = DIGITS * NIB_W;

    // Patterns are written g..a, matching the bit order of the buses.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/sseg_capture_decoder_if.sv
// ----------------------------------------------------------------------------
// sseg_capture_decoder_if
// Bundles the four raw segment buses and the decoded results.
//   HEX0_in..HEX3_in  7   asynchronous active-low segment buses (digit 0..3)
//   Value             16  last successfully decoded word
//   Valid             1   one-cycle pulse, Value just updated
//   Error             1   one-cycle pulse, settled pattern had a bad digit
//   ErrDigit          4   per-digit invalid mask of the last settled pattern
//   Locked            1   settled pattern unchanged since last decode
//   BlankDigit        4   per-digit blank mask (only with SSEG_BLANK_EN)
// Modports: master = pattern source / result consumer, slave = decoder.
// ----------------------------------------------------------------------------
interface sseg_capture_decoder_if;
    import sseg_pkg::*;

    logic [SEG_W-1:0]   HEX0_in;
    logic [SEG_W-1:0]   HEX1_in;
    logic [SEG_W-1:0]   HEX2_in;
    logic [SEG_W-1:0]   HEX3_in;
    logic [VALUE_W-1:0] Value;
    logic               Valid;
    logic               Error;
    logic [DIGITS-1:0]  ErrDigit;
    logic               Locked;
`ifdef SSEG_BLANK_EN
    logic [DIGITS-1:0]  BlankDigit;
`endif

    modport master (
        output HEX0_in, HEX1_in, HEX2_in, HEX3_in,
`ifdef SSEG_BLANK_EN
        input  BlankDigit,
`endif
        input  Value, Valid, Error, ErrDigit, Locked
    );

    modport slave (
        input  HEX0_in, HEX1_in, HEX2_in, HEX3_in,
`ifdef SSEG_BLANK_EN
        output BlankDigit,
`endif
        output Value, Valid, Error, ErrDigit, Locked
    );

endinterface

// File: rtl/sseg_digit_decode.sv
// ----------------------------------------------------------------------------
// sseg_digit_decode
// Combinational map of one active-low 7-segment pattern to its hex value.
//   seg    in   7  pattern, bit0 = a .. bit6 = g, 0 = segment lit
//   value  out  4  decoded hex value (0 when invalid)
//   blank  out  1  pattern is all-off (only with SSEG_BLANK_EN)
//   valid  out  1  pattern is one of the recognised glyphs
// Optional feature macro: SSEG_BLANK_EN makes the all-off pattern a valid
// digit that decodes to 0 and raises blank.
// ----------------------------------------------------------------------------
module sseg_digit_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [NIB_W-1:0] value,
`ifdef SSEG_BLANK_EN
    output logic             blank,
`endif
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        value = '0;
        valid = 1'b1;
`ifdef SSEG_BLANK_EN
        blank = 1'b0;
`endif
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
`ifdef SSEG_BLANK_EN
            SEG_BLANK: begin
                value = 4'h0;
                blank = 1'b1;
            end
`endif
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_capture_decoder.sv
// ----------------------------------------------------------------------------
// sseg_capture_decoder
// Samples four asynchronous seven-segment buses, waits until the whole
// 28-bit pattern has been unchanged for STABLE_CYCLES cycles, then decodes
// it once and reports the result with a one-cycle Valid or Error pulse.
//   CLOCK_50  in  1  system clock, rising edge
//   Reset     in  1  asynchronous, active-high
//   bus       sseg_capture_decoder_if.slave (segment inputs, decoded outputs)
// Parameters:
//   SYNC_STAGES   flops per input synchronizer chain (>= 2)
//   STABLE_CYCLES unchanged synchronized cycles needed before decode (>= 1)
// Optional feature macro: SSEG_BLANK_EN (all-off digits are valid and are
// reported on BlankDigit).
// ----------------------------------------------------------------------------
module sseg_capture_decoder
    import sseg_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                       CLOCK_50,
    input  logic                       Reset,
    sseg_capture_decoder_if.slave      bus
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizers and change detection
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]                   raw_word;
    logic [SYNC_STAGES-1:0][WORD_W-1:0]  sync_q;
    logic [WORD_W-1:0]                   s_word;
    logic [WORD_W-1:0]                   p_q;
    logic [SYNC_STAGES:0]                fill_q;
    logic                                primed;
    logic                                changed;

    assign raw_word = {bus.HEX3_in, bus.HEX2_in, bus.HEX1_in, bus.HEX0_in};
    assign s_word   = sync_q[SYNC_STAGES-1];

    // fill_q marks when the first post-reset sample has crossed the chain
    // and been copied into p_q. Until then the word counts as changed, so a
    // pattern already present during reset is decoded with the same latency
    // as one applied later (the reset value 7F would otherwise look settled).
    assign primed  = fill_q[SYNC_STAGES];
    assign changed = (s_word != p_q) || !primed;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sync_q <= '1;
            p_q    <= '1;
            fill_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its predecessor held before the edge, giving a true shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_word};
            p_q    <= s_word;
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Per-digit decode of the synchronized word
    // ------------------------------------------------------------------
    logic [VALUE_W-1:0] dec_value;
    logic [DIGITS-1:0]  dec_valid;
`ifdef SSEG_BLANK_EN
    logic [DIGITS-1:0]  dec_blank;
`endif

    for (genvar d = 0; d < DIGITS; d++) begin : g_dec
        sseg_digit_decode u_dec (
            .seg   (s_word[d*SEG_W +: SEG_W]),
            .value (dec_value[d*NIB_W +: NIB_W]),
`ifdef SSEG_BLANK_EN
            .blank (dec_blank[d]),
`endif
            .valid (dec_valid[d])
        );
    end

    // ------------------------------------------------------------------
    // Settle / lock FSM with registered outputs
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [VALUE_W-1:0] value_q;
    logic               valid_q;
    logic               error_q;
    logic [DIGITS-1:0]  err_digit_q;
    logic               locked_q;
`ifdef SSEG_BLANK_EN
    logic [DIGITS-1:0]  blank_q;
`endif

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_SETTLE;
            count_q     <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_digit_q <= '0;
            locked_q    <= 1'b0;
`ifdef SSEG_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    if (changed) begin
                        count_q <= '0;
                    end else if (count_q >= CNT_LAST) begin
                        // Decode on the stable word; s_word equals p_q here,
                        // so a change just entering the chain is not seen.
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        if (&dec_valid) begin
                            value_q     <= dec_value;
                            valid_q     <= 1'b1;
                            err_digit_q <= '0;
`ifdef SSEG_BLANK_EN
                            blank_q     <= dec_blank;
`endif
                        end else begin
                            error_q     <= 1'b1;
                            err_digit_q <= ~dec_valid;
                        end
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (changed) begin
                        state_q  <= ST_SETTLE;
                        count_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SETTLE;
                    count_q  <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Value    = value_q;
    assign bus.Valid    = valid_q;
    assign bus.Error    = error_q;
    assign bus.ErrDigit = err_digit_q;
    assign bus.Locked   = locked_q;
`ifdef SSEG_BLANK_EN
    assign bus.BlankDigit = blank_q;
`endif

endmodule

// File: tb/tb_sseg_capture_decoder.sv
// ----------------------------------------------------------------------------
// tb_sseg_capture_decoder
// Self-checking bench for sseg_capture_decoder (SYNC_STAGES=2,
// STABLE_CYCLES=4, so a held pattern decodes 7 edges after first sampled).
// Table-driven decode vectors plus hand-written sequences for reset, glitch,
// change-at-decode-edge and reset-while-settling. Honours SSEG_BLANK_EN.
// ----------------------------------------------------------------------------
module tb_sseg_capture_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sseg_capture_decoder_if bus ();

    sseg_capture_decoder #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    logic [6:0] seg_tab [16];

    typedef struct {
        logic [6:0]  h3, h2, h1, h0;
        bit          exp_valid;
        logic [15:0] exp_value;
        logic [3:0]  exp_err;
        logic [3:0]  exp_blank;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] h3, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
        bus.HEX3_in = h3;
        bus.HEX2_in = h2;
        bus.HEX1_in = h1;
        bus.HEX0_in = h0;
    endtask

    // Steps n edges; the pulse must appear at edge n and not before, and
    // Locked must still be low one edge earlier.
    task automatic run_to_decode(input string tag, input int n, input bit exp_valid);
        int   early = 0;
        logic locked_before = 1'b0;
        for (int e = 1; e <= n; e++) begin
            tick();
            if (e < n && (bus.Valid || bus.Error)) early++;
            if (e == n - 1) locked_before = bus.Locked;
        end
        check({tag, " early pulse"}, 32'(early), 32'(0));
        check({tag, " locked before decode"}, 32'(locked_before), 32'(0));
        check({tag, " Valid"}, 32'(bus.Valid), 32'(exp_valid));
        check({tag, " Error"}, 32'(bus.Error), 32'(!exp_valid));
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int e = 0; e < n; e++) begin
            tick();
            if (bus.Valid || bus.Error) pulses++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " Value"},    32'(bus.Value),    32'(16'h0000));
        check({tag, " Valid"},    32'(bus.Valid),    32'(0));
        check({tag, " Error"},    32'(bus.Error),    32'(0));
        check({tag, " ErrDigit"}, 32'(bus.ErrDigit), 32'(4'h0));
        check({tag, " Locked"},   32'(bus.Locked),   32'(0));
`ifdef SSEG_BLANK_EN
        check({tag, " BlankDigit"}, 32'(bus.BlankDigit), 32'(4'h0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   pulses;
        vec_t v;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        // Sweep: every table entry appears on every digit, digits rotated.
        for (int k = 0; k < 16; k++) begin
            v.h3 = seg_tab[(k + 15) % 16];
            v.h2 = seg_tab[(k + 10) % 16];
            v.h1 = seg_tab[(k + 5) % 16];
            v.h0 = seg_tab[k];
            v.exp_valid = 1'b1;
            v.exp_value = {4'((k + 15) % 16), 4'((k + 10) % 16), 4'((k + 5) % 16), 4'(k)};
            v.exp_err   = 4'h0;
            v.exp_blank = 4'h0;
            vecs.push_back(v);
        end
        // Last sweep value is 16'hE94F; error vectors keep it.
        vecs.push_back('{seg_tab[1], 7'b1111110, seg_tab[3], seg_tab[4], 1'b0, 16'hE94F, 4'b0100, 4'h0});
        vecs.push_back('{7'b1111110, seg_tab[2], 7'b0000001, seg_tab[4], 1'b0, 16'hE94F, 4'b1010, 4'h0});
`ifdef SSEG_BLANK_EN
        vecs.push_back('{seg_tab[12], seg_tab[0], 7'h7F, seg_tab[13], 1'b1, 16'hC00D, 4'h0, 4'b0010});
`else
        vecs.push_back('{seg_tab[12], seg_tab[0], 7'h7F, seg_tab[13], 1'b0, 16'hE94F, 4'b0010, 4'h0});
`endif
        vecs.push_back('{seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 1'b1, 16'h1234, 4'h0, 4'h0});

        // ---- 1: reset, all digits blank --------------------------------
        drive(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
`ifdef SSEG_BLANK_EN
        run_to_decode("t1 blank", 7, 1'b1);
        check("t1 Value",      32'(bus.Value),      32'(16'h0000));
        check("t1 ErrDigit",   32'(bus.ErrDigit),   32'(4'h0));
        check("t1 BlankDigit", 32'(bus.BlankDigit), 32'(4'hF));
`else
        run_to_decode("t1 blank", 7, 1'b0);
        check("t1 ErrDigit", 32'(bus.ErrDigit), 32'(4'hF));
        check("t1 Value",    32'(bus.Value),    32'(16'h0000));
`endif
        tick();
        check("t1 pulse ends", 32'(bus.Valid | bus.Error), 32'(0));
        check("t1 Locked",     32'(bus.Locked),            32'(1));

        // ---- 2: 1234, single pulse, stays locked -----------------------
        drive(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4]);
        run_to_decode("t2", 7, 1'b1);
        check("t2 Value",    32'(bus.Value),    32'(16'h1234));
        check("t2 ErrDigit", 32'(bus.ErrDigit), 32'(4'h0));
        count_pulses(12, pulses);
        check("t2 no repeat pulse", 32'(pulses),     32'(0));
        check("t2 Locked held",     32'(bus.Locked), 32'(1));

        // ---- 3: two-cycle glitch on HEX0 -------------------------------
        drive(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[8]);
        count_pulses(2, pulses);
        drive(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4]);
        check("t3 glitch pulses", 32'(pulses),    32'(0));
        check("t3 Value held",    32'(bus.Value), 32'(16'h1234));
        run_to_decode("t3 after glitch", 7, 1'b1);
        check("t3 Value", 32'(bus.Value), 32'(16'h1234));

        // ---- 4/5: table-driven sweep and invalid digits ----------------
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].h3, vecs[i].h2, vecs[i].h1, vecs[i].h0);
            run_to_decode(tag, 7, vecs[i].exp_valid);
            check({tag, " Value"},    32'(bus.Value),    32'(vecs[i].exp_value));
            check({tag, " ErrDigit"}, 32'(bus.ErrDigit), 32'(vecs[i].exp_err));
`ifdef SSEG_BLANK_EN
            check({tag, " BlankDigit"}, 32'(bus.BlankDigit), 32'(vecs[i].exp_blank));
`endif
            tick();
            check({tag, " Locked"},        32'(bus.Locked),   32'(1));
            check({tag, " ErrDigit held"}, 32'(bus.ErrDigit), 32'(vecs[i].exp_err));
        end

        // ---- change arriving at the decode edge ------------------------
        drive(seg_tab[9], seg_tab[10], seg_tab[11], seg_tab[12]);
        count_pulses(5, pulses);
        check("edge A early pulses", 32'(pulses), 32'(0));
        drive(seg_tab[13], seg_tab[14], seg_tab[15], seg_tab[0]);
        tick();
        tick();
        check("edge A Valid",  32'(bus.Valid),  32'(1));
        check("edge A Value",  32'(bus.Value),  32'(16'h9ABC));
        check("edge A Locked", 32'(bus.Locked), 32'(1));
        tick();
        check("edge leave Locked", 32'(bus.Locked),            32'(0));
        check("edge no pulse",     32'(bus.Valid | bus.Error), 32'(0));
        run_to_decode("edge B", 4, 1'b1);
        check("edge B Value", 32'(bus.Value), 32'(16'hDEF0));

        // ---- 6: reset two cycles into SETTLE ---------------------------
        drive(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8]);
        count_pulses(5, pulses);
        check("t6 pre-reset pulses", 32'(pulses), 32'(0));
        rst = 1'b1;
        #1;
        check_reset_outputs("t6 reset");
        tick();
        rst = 1'b0;
        run_to_decode("t6", 7, 1'b1);
        check("t6 Value",    32'(bus.Value),    32'(16'h5678));
        check("t6 ErrDigit", 32'(bus.ErrDigit), 32'(4'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
